// File: rtl/pipe_sched_if.sv
// Decode-stage issue handshake between fetch, pipe_sched and decode.
// Carries source/dest indices, redirects, writeback retire and scheduler outputs.
interface pipe_sched_if #(
    parameter int unsigned CNT_W = 16
);
    logic             fetch_valid;
    logic [4:0]       rs_idx;
    logic [4:0]       rt_idx;
    logic             rt_used;
    logic [4:0]       rd_idx;
    logic             rd_wr;
    logic             is_load;
    logic             jmp;
    logic             br_taken;
    logic             wb_valid;
    logic [4:0]       wb_idx;
    logic             issue;
    logic             stall;
    logic             flush;
    logic [31:0]      busy_mask;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output fetch_valid, rs_idx, rt_idx, rt_used,
        output rd_idx, rd_wr, is_load, jmp, br_taken,
        output wb_valid, wb_idx,
        input  issue, stall, flush, busy_mask, stall_cnt
    );

    modport slave (
        input  fetch_valid, rs_idx, rt_idx, rt_used,
        input  rd_idx, rd_wr, is_load, jmp, br_taken,
        input  wb_valid, wb_idx,
        output issue, stall, flush, busy_mask, stall_cnt
    );
endinterface

// File: rtl/pipe_sched.sv
// Decode issue scheduler: RAW scoreboard, redirect flush, stall counter.
// Optional PIPE_SCHED_FWD_EN: only load-use hazards stall (ALU forwarding).
module pipe_sched #(
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned CNT_W     = 16
) (
    input logic         clk,
    input logic         rst,
    pipe_sched_if.slave bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYC - 1);

    state_t           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic             flush_q;
    logic [31:0]      busy_q, busy_d;
    logic [31:0]      set_vec, clr_vec, haz_mask;
    logic [CNT_W-1:0] cnt_q;
    logic             hazard, issue, stall;

`ifdef PIPE_SCHED_FWD_EN
    logic [31:0] ld_q, ld_d;
    assign haz_mask = busy_q & ld_q;
`else
    assign haz_mask = busy_q;
`endif

    assign hazard = haz_mask[bus.rs_idx] |
                    (bus.rt_used & haz_mask[bus.rt_idx]);

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        issue   = 1'b0;
        stall   = 1'b0;
        if (bus.br_taken) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_LD;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.fetch_valid) begin
                        if (hazard) begin
                            stall   = 1'b1;
                            state_d = STALL;
                        end else begin
                            issue = 1'b1;
                        end
                    end
                end
                STALL: begin
                    if (hazard) begin
                        stall = 1'b1;
                    end else begin
                        issue   = bus.fetch_valid;
                        state_d = RUN;
                    end
                end
                FLUSH: begin
                    if (fcnt_q == 3'd0) state_d = RUN;
                    else fcnt_d = fcnt_q - 3'd1;
                end
                default: state_d = RUN;
            endcase
            if (issue && bus.jmp) begin
                state_d = FLUSH;
                fcnt_d  = FLUSH_LD;
            end
        end
        // Decode must never see an enable while the pipe is held in reset
        if (!rst) begin
            issue = 1'b0;
            stall = 1'b0;
        end
    end

    assign set_vec = (issue && bus.rd_wr && bus.rd_idx != 5'd0) ?
                     (32'd1 << bus.rd_idx) : 32'd0;
    assign clr_vec = bus.wb_valid ? (32'd1 << bus.wb_idx) : 32'd0;
    assign busy_d  = (busy_q & ~clr_vec) | set_vec;

`ifdef PIPE_SCHED_FWD_EN
    assign ld_d = (ld_q & ~clr_vec & ~set_vec) |
                  (bus.is_load ? set_vec : 32'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ld_q <= '0;
        else      ld_q <= ld_d;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            flush_q <= 1'b0;
            busy_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            flush_q <= (state_d == FLUSH);
            busy_q  <= busy_d;
            if (stall && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.issue     = issue;
    assign bus.stall     = stall;
    assign bus.flush     = flush_q;
    assign bus.busy_mask = busy_q;
    assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched: issue, RAW stalls, flush, scoreboard, reset.
// Expected values are hand-derived per cycle; both FWD configurations covered.
module tb_pipe_sched;
    logic clk = 1'b0;
    logic rst;
    int   n_asrt = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pipe_sched_if #(.CNT_W(16)) bus ();

    pipe_sched #(.FLUSH_CYC(2), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_asrt++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic fv, input logic [4:0] rs,
                       input logic [4:0] rt, input logic rtu,
                       input logic [4:0] rd, input logic wr,
                       input logic ld, input logic j);
        bus.fetch_valid = fv;
        bus.rs_idx      = rs;
        bus.rt_idx      = rt;
        bus.rt_used     = rtu;
        bus.rd_idx      = rd;
        bus.rd_wr       = wr;
        bus.is_load     = ld;
        bus.jmp         = j;
        #1;
    endtask

    task automatic wb(input logic v, input logic [4:0] idx);
        bus.wb_valid = v;
        bus.wb_idx   = idx;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst          = 1'b0;
        bus.br_taken = 1'b0;
        wb(1'b0, 5'd0);
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        check("rst_issue", {31'd0, bus.issue}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_flush", {31'd0, bus.flush}, 32'd0);
        check("rst_busy",  bus.busy_mask, 32'd0);
        check("rst_cnt",   {16'd0, bus.stall_cnt}, 32'd0);
        rst = 1'b1;

        // four independent producers r1..r4
        for (int i = 1; i <= 4; i++) begin
            drv(1'b1, 5'd0, 5'd0, 1'b0, 5'(i), 1'b1, 1'b0, 1'b0);
            check($sformatf("indep_issue%0d", i), {31'd0, bus.issue}, 32'd1);
            tick();
        end
        idle();
        check("indep_busy", bus.busy_mask, 32'h0000_001E);
        for (int i = 1; i <= 4; i++) begin
            wb(1'b1, 5'(i));
            tick();
        end
        wb(1'b0, 5'd0);
        check("indep_clear", bus.busy_mask, 32'd0);

        // add r3 then a reader of r3, writeback of r3 two cycles later
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        check("alu_prod_issue", {31'd0, bus.issue}, 32'd1);
        tick();
        drv(1'b1, 5'd3, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_SCHED_FWD_EN
        check("alu_fwd_issue", {31'd0, bus.issue}, 32'd1);
        tick();
        idle();
        wb(1'b1, 5'd3);
        tick();
        wb(1'b0, 5'd0);
        check("alu_cnt", {16'd0, bus.stall_cnt}, 32'd0);
`else
        check("alu_stall1", {31'd0, bus.stall}, 32'd1);
        check("alu_noissue", {31'd0, bus.issue}, 32'd0);
        tick();
        wb(1'b1, 5'd3);
        check("alu_stall2", {31'd0, bus.stall}, 32'd1);
        tick();
        wb(1'b0, 5'd0);
        check("alu_issue", {31'd0, bus.issue}, 32'd1);
        check("alu_nostall", {31'd0, bus.stall}, 32'd0);
        check("alu_cnt", {16'd0, bus.stall_cnt}, 32'd2);
        tick();
        idle();
`endif
        check("alu_busy", bus.busy_mask, 32'h0000_0040);
        wb(1'b1, 5'd6);
        tick();
        wb(1'b0, 5'd0);

        // lw r5 then a reader of r5 via rt: load-use in both builds
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        check("lw_issue", {31'd0, bus.issue}, 32'd1);
        tick();
        drv(1'b1, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("lu_stall1", {31'd0, bus.stall}, 32'd1);
        tick();
        check("lu_stall2", {31'd0, bus.stall}, 32'd1);
        tick();
        wb(1'b1, 5'd5);
        check("lu_stall3", {31'd0, bus.stall}, 32'd1);
        tick();
        wb(1'b0, 5'd0);
        check("lu_issue", {31'd0, bus.issue}, 32'd1);
`ifdef PIPE_SCHED_FWD_EN
        check("lu_cnt", {16'd0, bus.stall_cnt}, 32'd3);
`else
        check("lu_cnt", {16'd0, bus.stall_cnt}, 32'd5);
`endif
        tick();
        idle();

        // taken branch while stalled on lw r9
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        drv(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("br_pre_stall", {31'd0, bus.stall}, 32'd1);
        tick();
        bus.br_taken = 1'b1;
        #1;
        check("br_noissue", {31'd0, bus.issue}, 32'd0);
        check("br_flush_lag", {31'd0, bus.flush}, 32'd0);
        tick();
        bus.br_taken = 1'b0;
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("br_flush1", {31'd0, bus.flush}, 32'd1);
        check("br_fl_noissue", {31'd0, bus.issue}, 32'd0);
        tick();
        check("br_flush2", {31'd0, bus.flush}, 32'd1);
        tick();
        check("br_flush_end", {31'd0, bus.flush}, 32'd0);
        check("br_run_issue", {31'd0, bus.issue}, 32'd1);
`ifdef PIPE_SCHED_FWD_EN
        check("br_cnt", {16'd0, bus.stall_cnt}, 32'd4);
`else
        check("br_cnt", {16'd0, bus.stall_cnt}, 32'd6);
`endif
        tick();
        idle();
        wb(1'b1, 5'd9);
        tick();
        wb(1'b0, 5'd0);

        // jump issued in RUN redirects fetch
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        check("jmp_issue", {31'd0, bus.issue}, 32'd1);
        tick();
        idle();
        check("jmp_flush1", {31'd0, bus.flush}, 32'd1);
        tick();
        check("jmp_flush2", {31'd0, bus.flush}, 32'd1);
        tick();
        check("jmp_flush_end", {31'd0, bus.flush}, 32'd0);

        // same-cycle set/clear of r7, then a write to r0
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        wb(1'b1, 5'd7);
        tick();
        wb(1'b0, 5'd0);
        check("setwin_busy", bus.busy_mask, 32'h0000_0080);
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        check("r0_issue", {31'd0, bus.issue}, 32'd1);
        tick();
        idle();
        check("r0_busy", bus.busy_mask, 32'h0000_0080);
        wb(1'b1, 5'd7);
        tick();
        wb(1'b0, 5'd0);

        // asynchronous reset in the middle of a flush
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        bus.br_taken = 1'b1;
        #1;
        tick();
        bus.br_taken = 1'b0;
        check("ar_flush_pre", {31'd0, bus.flush}, 32'd1);
        check("ar_busy_pre", bus.busy_mask, 32'h0000_0400);
        #1;
        rst = 1'b0;
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("ar_flush", {31'd0, bus.flush}, 32'd0);
        check("ar_busy", bus.busy_mask, 32'd0);
        check("ar_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        check("ar_issue", {31'd0, bus.issue}, 32'd0);
        tick();
        idle();
        rst = 1'b1;

        // long load-use stall to saturate the counter
        drv(1'b1, 5'd0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
        check("sat_lw_issue", {31'd0, bus.issue}, 32'd1);
        tick();
        drv(1'b1, 5'd11, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (65540) tick();
        check("sat_stall", {31'd0, bus.stall}, 32'd1);
        check("sat_cnt", {16'd0, bus.stall_cnt}, 32'h0000_FFFF);
        wb(1'b1, 5'd11);
        tick();
        wb(1'b0, 5'd0);
        check("sat_release", {31'd0, bus.issue}, 32'd1);
        check("sat_hold", {16'd0, bus.stall_cnt}, 32'h0000_FFFF);
        tick();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end
endmodule
